// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and counter sizing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int cnt_width(input int clks);
    return $clog2(clks);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input with a configurable reset value
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk)
    if (rst) {o_q, r_meta} <= {RST_VAL, RST_VAL};
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with a one-byte valid/ready output buffer and error pulses
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] uart_rx,
  output logic                      uart_rx_valid,
  input  logic                      uart_rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);
  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic                      w_rx_s;
  logic                      w_free;
  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_prev;
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(rx),
    .o_q(w_rx_s)
  );
  // a byte held in the buffer is still replaceable if it is being taken this cycle
  assign w_free = !uart_rx_valid || uart_rx_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_prev        <= 1'b1;
      uart_rx       <= '0;
      uart_rx_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      r_prev    <= w_rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (uart_rx_valid && uart_rx_ready) uart_rx_valid <= 1'b0;
      case (r_state)
        IDLE: if (r_prev && !w_rx_s) begin
          r_cnt   <= '0;
          r_state <= START;
        end
        START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= w_rx_s ? IDLE : DATA;
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (r_cnt == LAST) begin
          r_cnt          <= '0;
          r_shift[r_idx] <= w_rx_s;
          r_idx          <= r_idx + 1'b1;
          if (r_idx == 3'(UART_DATA_BITS - 1)) r_state <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
        STOP: if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_state   <= w_rx_s ? IDLE : BREAK;
          frame_err <= !w_rx_s;
          overrun   <= w_rx_s && !w_free;
          if (w_rx_s && w_free) begin
            uart_rx       <= r_shift;
            uart_rx_valid <= 1'b1;
          end
        end else r_cnt <= r_cnt + 1'b1;
        BREAK: if (w_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: randomized and directed bench with a frame-level reference model of the receiver
module tb_uart_rx_deser;
  localparam int C = 16;
  localparam int STOP_LAT = 2 + C / 2 + 9 * C;
  logic clk = 0, rst = 1, rx = 1, uart_rx_ready = 0;
  logic [7:0] uart_rx;
  logic uart_rx_valid, frame_err, overrun;
  int cyc = 0, nchk = 0, nerr = 0, rdy_at = -1;
  bit rand_rdy = 0;
  bit m_valid, m_fe, m_ov;
  bit [7:0] m_data;
  bit [1:0] ev_kind [16384];
  bit [7:0] ev_byte [16384];
  logic [7:0] got[$];
  int rises[$];
  int fe_n = 0, ov_n = 0, ov_cyc = -1;
  bit pv = 0;

  uart_rx_deser #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx(rx), .uart_rx(uart_rx), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference: each sent frame resolves at its stop-sample cycle into a buffered byte,
  // an overrun (buffer occupied and not being drained) or a framing error.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_valid <= 0; m_data <= 0; m_fe <= 0; m_ov <= 0;
    end else begin
      m_fe <= ev_kind[cyc] == 2;
      m_ov <= ev_kind[cyc] == 1 && m_valid && !uart_rx_ready;
      if (ev_kind[cyc] == 1 && (!m_valid || uart_rx_ready)) begin
        m_valid <= 1; m_data <= ev_byte[cyc];
      end else if (uart_rx_ready) m_valid <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) uart_rx_ready = 1'($urandom_range(0, 1));
      if (cyc == rdy_at) uart_rx_ready = 1;
    end
  endtask

  // rst_bit >= 0 pulses reset mid-way through that data bit and leaves the frame unscheduled
  task automatic send_frame(input logic [7:0] b, input bit stop, input int rst_bit);
    int c;
    c = cyc;
    if (rst_bit < 0) begin
      ev_kind[c + STOP_LAT] = stop ? 2'd1 : 2'd2;
      ev_byte[c + STOP_LAT] = b;
    end
    rx = 0;
    tick(C);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == rst_bit) begin
        tick(C / 2); rst = 1; tick(1); rst = 0;
        chk("rst_valid", uart_rx_valid, 0);
        chk("rst_data", uart_rx, 0);
        tick(C / 2 - 1);
      end else tick(C);
    end
    rx = stop;
    tick(C);
  endtask

  task automatic chk_got(input string name, input int base, input bit [7:0] e[$]);
    chk({name, "_count"}, got.size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < got.size(); i++) chk(name, got[base + i], e[i]);
  endtask

  initial begin
    int base, fe0, ov0, c, nr;
    fork
      forever begin
        @(negedge clk);
        chk("valid", uart_rx_valid, m_valid);
        chk("data", uart_rx, m_data);
        chk("frame_err", frame_err, m_fe);
        chk("overrun", overrun, m_ov);
        if (uart_rx_valid && !pv) rises.push_back(cyc);
        if (uart_rx_valid && uart_rx_ready) got.push_back(uart_rx);
        if (frame_err) fe_n++;
        if (overrun) begin ov_n++; ov_cyc = cyc; end
        pv = uart_rx_valid;
      end
    join_none
    tick(3);
    rst = 0;
    chk("reset_valid", uart_rx_valid, 0);
    chk("reset_data", uart_rx, 0);
    chk("reset_fe", frame_err, 0);
    chk("reset_ov", overrun, 0);
    tick(5);
    // single byte, latency pinned to 155 cycles from the pin edge
    uart_rx_ready = 1; base = got.size(); fe0 = fe_n; ov0 = ov_n; nr = rises.size(); c = cyc;
    send_frame(8'hA5, 1, -1);
    tick(10);
    chk("s1_latency", rises.size() > nr ? rises[nr] - c : -1, 155);
    chk_got("s1_byte", base, '{8'hA5});
    chk("s1_errs", fe_n + ov_n - fe0 - ov0, 0);
    // back-to-back frames
    base = got.size();
    send_frame(8'h00, 1, -1); send_frame(8'hFF, 1, -1); send_frame(8'h55, 1, -1);
    tick(10);
    chk_got("s2_seq", base, '{8'h00, 8'hFF, 8'h55});
    // overrun while ready is held low
    uart_rx_ready = 0; base = got.size(); ov0 = ov_n;
    send_frame(8'h12, 1, -1);
    c = cyc;
    send_frame(8'h34, 1, -1);
    tick(10);
    chk("s3_hold", uart_rx, 8'h12);
    chk("s3_ov_count", ov_n - ov0, 1);
    chk("s3_ov_cycle", ov_cyc - c, 155);
    uart_rx_ready = 1; tick(5);
    chk_got("s3_drain", base, '{8'h12});
    // framing error, long break, then a clean frame
    base = got.size(); fe0 = fe_n; ov0 = ov_n;
    send_frame(8'h3C, 0, -1);
    tick(40 * C);
    rx = 1; tick(2 * C);
    send_frame(8'h7E, 1, -1);
    tick(10);
    chk("s4_fe_count", fe_n - fe0, 1);
    chk_got("s4_bytes", base, '{8'h7E});
    chk("s4_ov", ov_n - ov0, 0);
    // glitch, then reset mid-frame with a byte pending
    base = got.size(); fe0 = fe_n; ov0 = ov_n;
    rx = 0; tick(4); rx = 1; tick(3 * C);
    chk_got("s5_glitch", base, '{});
    chk("s5_glitch_errs", fe_n + ov_n - fe0 - ov0, 0);
    uart_rx_ready = 0;
    send_frame(8'h5A, 1, -1);
    tick(5);
    chk("s5_pending", uart_rx_valid, 1);
    send_frame(8'hF0, 1, 4);
    uart_rx_ready = 1; tick(C);
    send_frame(8'hC3, 1, -1);
    tick(10);
    chk_got("s5_after_rst", base, '{8'hC3});
    // ready rises exactly in the cycle the next byte loads
    uart_rx_ready = 0; base = got.size(); ov0 = ov_n;
    send_frame(8'h11, 1, -1);
    rdy_at = cyc + STOP_LAT;
    send_frame(8'h22, 1, -1);
    tick(5);
    rdy_at = -1;
    chk_got("s6_seq", base, '{8'h11, 8'h22});
    chk("s6_ov", ov_n - ov0, 0);
    // randomized frames and ready, checked cycle by cycle against the model
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      bit st;
      st = $urandom_range(0, 7) != 0;
      send_frame(8'($urandom), st, -1);
      if (!st) begin rx = 1; tick(C + $urandom_range(0, 10)); end
      else tick($urandom_range(0, 20));
    end
    rand_rdy = 0; uart_rx_ready = 1;
    tick(12 * C);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-byte UART receiver (8N1, LSB first) that converts the asynchronous RX pin into the byte stream consumed by the debug command parser. It sits directly upstream of that parser and drives its uart_rx / uart_rx_valid / uart_rx_ready byte channel. It holds one received byte in a single output buffer and reports framing and overrun errors as single-cycle pulses.

## Interface
- CLKS_PER_BIT, default 104: clock cycles per UART bit; integer, minimum 4.
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- rx  in  1  asynchronous serial line; idles high.
- uart_rx  out  8  received byte; stable while uart_rx_valid is high.
- uart_rx_valid  out  1  byte available.
- uart_rx_ready  in  1  consumer accepts the byte.
- frame_err  out  1  one-cycle pulse: stop bit was sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the buffer was full.

## Operation
- Input conditioning: rx passes through a 2-flop synchronizer. Both flops reset to 1. The FSM sees rx_s, which lags the pin by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a falling edge on rx_s (previous 1, current 0) clears the baud counter and moves to START.
  - START: counts CLKS_PER_BIT/2 cycles (integer division), then samples rx_s.
    - If rx_s is 1 (glitch): return to IDLE. No output, no error.
    - If rx_s is 0: clear the bit index and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, samples rx_s into shift[bit_idx], LSB first. After bit 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, samples rx_s.
    - If rx_s is 1 and the buffer is free (see below): load the byte, set uart_rx_valid, go to IDLE.
    - If rx_s is 1 and the buffer is full: drop the new byte, pulse overrun, keep the old byte, go to IDLE.
    - If rx_s is 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: waits until rx_s is 1, then goes to IDLE. This prevents a break condition from being re-detected as a start bit.
- Buffer is free when uart_rx_valid is 0, or when uart_rx_valid & uart_rx_ready is true in that same cycle.
- Output handshake:
  - A transfer occurs on a cycle where uart_rx_valid & uart_rx_ready are both high.
  - After a transfer, uart_rx_valid drops the next cycle, unless a new byte loads in the same cycle; in that case uart_rx_valid stays 1 and uart_rx takes the new value.
  - uart_rx_valid never depends combinationally on uart_rx_ready.
  - uart_rx changes only on a load.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1, and that wrap cycle is the sample cycle.
  - bit_idx is 3 bits wide.
- Reset (applies in any state, including mid-frame):
  - state is IDLE; counters are 0; shift register is 0.
  - uart_rx=0x00, uart_rx_valid=0, frame_err=0, overrun=0.
  - After reset, a frame already in progress is ignored until the next falling edge on rx_s.

## Timing
- Sample points, relative to the cycle in which the falling edge is detected on rx_s:
  - start bit: +CLKS_PER_BIT/2
  - data bit k: +CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - stop bit: +CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- uart_rx_valid rises 1 cycle after the stop sample. Total from the pin falling edge: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. For CLKS_PER_BIT=16 this is 155.
- frame_err and overrun assert in the cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames (stop bit followed immediately by a start bit) are received with no loss. The FSM returns to IDLE roughly CLKS_PER_BIT/2 cycles before the next start edge.
- Throughput is one byte per 10·CLKS_PER_BIT cycles. uart_rx_ready may stay low for up to one full frame without loss.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - UART_DATA_BITS=8;
  - a function computing the counter width from CLKS_PER_BIT.
- One sub-module, sync2: the 2-flop synchronizer with a reset value parameter (here 1). It is reused for other asynchronous inputs.
- Everything else (FSM, counters, shift register, output buffer) lives in uart_rx_deser.

## Test plan
Use CLKS_PER_BIT=16 for all scenarios.
1. Single byte: send 0xA5 with uart_rx_ready=1.
   - uart_rx_valid high at cycle 155 after the pin falling edge, with uart_rx=0xA5.
   - Transfer completes; uart_rx_valid is 0 the next cycle.
   - No error pulses.
2. Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap and ready held high.
   - Three transfers, in that order and with those values.
3. Overrun: hold uart_rx_ready=0 and send 0x12 then 0x34.
   - uart_rx stays 0x12.
   - overrun pulses once, 1 cycle after the second stop sample.
   - Raising ready then yields only 0x12.
4. Framing and break: send 0x3C with the stop bit low, then hold rx low for 40 bits, then send 0x7E.
   - frame_err pulses once; the 0x3C byte is never output.
   - The 40-bit low period produces no spurious byte.
   - 0x7E is received correctly.
5. Glitch and reset:
   - A 4-cycle low pulse on rx gives no output and no errors.
   - Asserting rst for 1 cycle in the middle of bit 4 of a frame clears uart_rx_valid and uart_rx to 0; the next full frame, 0xC3, is received correctly.
6. Simultaneous events: hold ready low until the cycle in which the next byte loads, then assert it.
   - uart_rx_valid stays 1 and uart_rx switches to the new byte.
   - No overrun pulse.
